// File: rtl/spm_op_driver.sv
// ---------------------------------------------------------------------------
// spm_op_driver
//
// Operand-side driver and product collector for the spm serial-parallel
// multiplier. A signed operand pair is taken on the in_* handshake. The
// multiplicand is then held on spm_x while the multiplier is streamed
// LSB-first, sign-extended to 2N bits, on spm_y. The serial product coming
// back on spm_p is deserialized into a 2N-bit signed result, which is
// returned on the out_* handshake.
//
// Parameters:
//   N    operand width; must match the attached spm instance.
//   LAT  cycles from a bit on spm_y to the matching bit on spm_p (0..4).
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready    operand handshake; in_x, in_y signed N-bit operands
//   out_valid/out_ready  product handshake; out_p signed 2N-bit product
//   spm_rst              clear to spm (high during rst and the CLR state)
//   spm_x                parallel multiplicand to spm
//   spm_y                serial multiplier bit to spm
//   spm_p                serial product bit from spm
//
// Optional build macro SPM_OP_DRIVER_STATS_EN adds:
//   op_count [15:0]      completed output handshakes, wraps at 0xFFFF
//   busy                 high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module spm_op_driver #(
    parameter int N   = 32,
    parameter int LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [N-1:0]   in_x,
    input  logic signed [N-1:0]   in_y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [2*N-1:0] out_p,
    output logic                  spm_rst,
    output logic signed [N-1:0]   spm_x,
    output logic                  spm_y,
    input  logic                  spm_p
`ifdef SPM_OP_DRIVER_STATS_EN
    ,
    output logic [15:0]           op_count,
    output logic                  busy
`endif
);

    // SHIFT and DRAIN share one cycle index k = 0 .. 2N+LAT-1.
    localparam int TOT = 2 * N + LAT;
    localparam int CW  = $clog2(TOT + 1);

    localparam logic [CW-1:0] LAT_C       = CW'(LAT);
    localparam logic [CW-1:0] SHIFT_END_C = CW'(2 * N - 1);
    localparam logic [CW-1:0] LAST_C      = CW'(TOT - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic signed [N-1:0]    xreg_q, xreg_d;
    logic signed [N-1:0]    yreg_q, yreg_d;
    logic signed [2*N-1:0]  preg_q, preg_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            xreg_q  <= '0;
            yreg_q  <= '0;
            preg_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            xreg_q  <= xreg_d;
            yreg_q  <= yreg_d;
            preg_q  <= preg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        xreg_d  = xreg_q;
        yreg_d  = yreg_q;
        preg_d  = preg_q;
        spm_y   = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    xreg_d  = in_x;
                    yreg_d  = in_y;
                    preg_d  = '0;
                    state_d = CLR;
                end
            end
            CLR: begin
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT, DRAIN: begin
                // The multiplier register shifts right arithmetically, so
                // bit 0 walks through y LSB-first and then repeats the sign
                // bit for the upper N positions and all of DRAIN.
                spm_y  = yreg_q[0];
                yreg_d = yreg_q >>> 1;
                // The first LAT cycles of spm_p are pipeline fill, not
                // product bits.
                if (cnt_q >= LAT_C) begin
                    preg_d = {spm_p, preg_q[2*N-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                // LAST is tested first so that LAT=0 skips DRAIN entirely.
                if (cnt_q == LAST_C) begin
                    state_d = DONE;
                end else if (cnt_q == SHIFT_END_C) begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = ~rst & (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_p     = preg_q;
    assign spm_x     = xreg_q;
    assign spm_rst   = rst | (state_q == CLR);

`ifdef SPM_OP_DRIVER_STATS_EN
    logic [15:0] op_count_q, op_count_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    always_comb begin
        op_count_d = op_count_q;
        if (out_valid && out_ready) begin
            op_count_d = op_count_q + 16'd1;
        end
    end

    assign op_count = op_count_q;
    assign busy     = (state_q != IDLE);
`endif

endmodule

// File: tb/tb_spm_op_driver.sv
module tb_spm_op_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared stimulus; each DUT has its own in_valid.
    logic               iv1 = 1'b0, iv2 = 1'b0;
    logic signed [7:0]  ix = '0, iy = '0;
    logic               ordy = 1'b1;

    // DUT 1: N=8, LAT=1
    logic               ir1, ov1, srst1, sy1, sp1;
    logic signed [15:0] op1;
    logic signed [7:0]  sx1;
    // DUT 2: N=8, LAT=2
    logic               ir2, ov2, srst2, sy2, sp2;
    logic signed [15:0] op2;
    logic signed [7:0]  sx2;
`ifdef SPM_OP_DRIVER_STATS_EN
    logic [15:0] cnt1, cnt2;
    logic        busy1, busy2;
`endif

    spm_op_driver #(.N(8), .LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(iv1), .in_ready(ir1), .in_x(ix), .in_y(iy),
        .out_valid(ov1), .out_ready(ordy), .out_p(op1),
        .spm_rst(srst1), .spm_x(sx1), .spm_y(sy1), .spm_p(sp1)
`ifdef SPM_OP_DRIVER_STATS_EN
        , .op_count(cnt1), .busy(busy1)
`endif
    );

    spm_op_driver #(.N(8), .LAT(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(iv2), .in_ready(ir2), .in_x(ix), .in_y(iy),
        .out_valid(ov2), .out_ready(ordy), .out_p(op2),
        .spm_rst(srst2), .spm_x(sx2), .spm_y(sy2), .spm_p(sp2)
`ifdef SPM_OP_DRIVER_STATS_EN
        , .op_count(cnt2), .busy(busy2)
`endif
    );

    // Behavioural spm: accumulates x_sext<<j for each y bit and emits bit j
    // of the running sum one cycle later (LAT=1). The second copy adds one
    // more register stage (LAT=2).
    logic [15:0] acc1 = '0, nxt1, acc2 = '0, nxt2;
    logic [4:0]  j1 = '0, j2 = '0;
    logic        p1 = 1'b0, p2 = 1'b0, p2d = 1'b0;

    always_comb nxt1 = acc1 + (sy1 ? ({{8{sx1[7]}}, sx1} << j1) : 16'd0);
    always_comb nxt2 = acc2 + (sy2 ? ({{8{sx2[7]}}, sx2} << j2) : 16'd0);

    always @(posedge clk) begin
        if (srst1) begin
            acc1 <= '0; j1 <= '0; p1 <= 1'b0;
        end else begin
            acc1 <= nxt1;
            p1   <= (j1 < 5'd16) ? nxt1[j1[3:0]] : 1'b0;
            if (j1 < 5'd31) j1 <= j1 + 5'd1;
        end
    end

    always @(posedge clk) begin
        p2d <= p2;
        if (srst2) begin
            acc2 <= '0; j2 <= '0; p2 <= 1'b0;
        end else begin
            acc2 <= nxt2;
            p2   <= (j2 < 5'd16) ? nxt2[j2[3:0]] : 1'b0;
            if (j2 < 5'd31) j2 <= j2 + 5'd1;
        end
    end

    assign sp1 = p1;
    assign sp2 = p2d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Scoreboards: expected products pushed at the input handshake, popped
    // at the output handshake.
    logic signed [15:0] q1[$];
    logic signed [15:0] q2[$];

    always @(negedge clk) begin
        if (!rst && ov1 && ordy) begin
            if (q1.size() == 0) chk("dut1 unexpected out_valid", {31'd0, ov1}, 32'd0);
            else chk("dut1 out_p", {16'd0, op1}, {16'd0, q1.pop_front()});
        end
        if (!rst && ov2 && ordy) begin
            if (q2.size() == 0) chk("dut2 unexpected out_valid", {31'd0, ov2}, 32'd0);
            else chk("dut2 out_p", {16'd0, op2}, {16'd0, q2.pop_front()});
        end
    end

    int   pulses1 = 0;
    logic srst1_prev = 1'b0;
    always @(negedge clk) begin
        srst1_prev <= srst1;
        if (!rst && srst1 && !srst1_prev) pulses1 <= pulses1 + 1;
    end

    int last_hs = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit sel, input logic signed [7:0] x, input logic signed [7:0] y);
        int n = 0;
        logic signed [15:0] e;
        ix = x;
        iy = y;
        if (sel) iv2 = 1'b1; else iv1 = 1'b1;
        while (!(sel ? ir2 : ir1) && n < 200) begin
            step();
            n++;
        end
        chk("in_ready wait", {31'd0, (sel ? ir2 : ir1)}, 32'd1);
        last_hs = cyc + 1;
        e = x * y;
        if (sel) q2.push_back(e); else q1.push_back(e);
        step();
        iv1 = 1'b0;
        iv2 = 1'b0;
    endtask

    task automatic wait_out(input bit sel);
        int n = 0;
        while (!(sel ? ov2 : ov1) && n < 200) begin
            step();
            n++;
        end
        chk("out_valid wait", {31'd0, (sel ? ov2 : ov1)}, 32'd1);
    endtask

    initial begin
        int n;
        int t0;
        int p0;
        logic        seen;
        logic        hold_ok;
        logic [15:0] held;

        // Reset state
        step();
        step();
        chk("rst in_ready", {31'd0, ir1}, 32'd0);
        chk("rst out_valid", {31'd0, ov1}, 32'd0);
        chk("rst out_p", {16'd0, op1}, 32'd0);
        chk("rst spm_x", {24'd0, sx1}, 32'd0);
        chk("rst spm_y", {31'd0, sy1}, 32'd0);
        chk("rst spm_rst", {31'd0, srst1}, 32'd1);
        rst = 1'b0;
        step();
        chk("idle in_ready", {31'd0, ir1}, 32'd1);
        chk("idle spm_rst", {31'd0, srst1}, 32'd0);
`ifdef SPM_OP_DRIVER_STATS_EN
        chk("rst op_count", {16'd0, cnt1}, 32'd0);
        chk("idle busy", {31'd0, busy1}, 32'd0);
`endif

        // 3*5 with latency measurement
        ordy = 1'b1;
        issue(1'b0, 8'sd3, 8'sd5);
        n = 0;
        while (!ov1 && n < 100) begin
            step();
            n++;
        end
        chk("latency", n, 32'd18);
        chk("3*5 value", {16'd0, op1}, 32'h000F);
        step();
        chk("idle after out", {31'd0, ir1}, 32'd1);

        // -128 * -128
        issue(1'b0, -8'sd128, -8'sd128);
        wait_out(1'b0);
        chk("-128*-128 value", {16'd0, op1}, 32'h4000);
        step();

        // -3*5 with out_ready held low for 10 cycles
        ordy = 1'b0;
        issue(1'b0, -8'sd3, 8'sd5);
        wait_out(1'b0);
        held = op1;
        chk("-3*5 value", {16'd0, held}, 32'h0000FFF1);
        hold_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!ov1 || op1 !== held || ir1) hold_ok = 1'b0;
        end
        chk("stall stable", {31'd0, hold_ok}, 32'd1);
        ordy = 1'b1;
        step();
        chk("release out_valid", {31'd0, ov1}, 32'd0);
        chk("release in_ready", {31'd0, ir1}, 32'd1);

        // Back-to-back 7*9 then -1*-1
        p0 = pulses1;
        issue(1'b0, 8'sd7, 8'sd9);
        t0 = last_hs;
        issue(1'b0, -8'sd1, -8'sd1);
        chk("throughput", last_hs - t0, 32'd20);
        wait_out(1'b0);
        chk("-1*-1 value", {16'd0, op1}, 32'h0001);
        step();
        chk("spm_rst pulses", pulses1 - p0, 32'd2);

        // Reset while SHIFT cnt=5
        issue(1'b0, 8'sd7, 8'sd9);
        for (int i = 0; i < 6; i++) step();
        rst = 1'b1;
        q1.delete();
        #1;
        chk("abort out_valid", {31'd0, ov1}, 32'd0);
        chk("abort in_ready", {31'd0, ir1}, 32'd0);
        step();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (ov1) seen = 1'b1;
        end
        chk("aborted op silent", {31'd0, seen}, 32'd0);
        issue(1'b0, 8'sd2, 8'sd2);
        wait_out(1'b0);
        chk("2*2 after abort", {16'd0, op1}, 32'h0004);
        step();

        // LAT=2 instance, 1000 random signed pairs
        for (int i = 0; i < 1000; i++) begin
            issue(1'b1, 8'($urandom), 8'($urandom));
        end
        n = 0;
        while ((q2.size() != 0) && n < 200) begin
            step();
            n++;
        end
        chk("dut2 drained", q2.size(), 32'd0);
        step();
`ifdef SPM_OP_DRIVER_STATS_EN
        chk("dut2 op_count", {16'd0, cnt2}, 32'd1000);
        chk("dut2 busy idle", {31'd0, busy2}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
